// File: rtl/b_cnt_pkg.sv
// Shared constants and edge-operation priority encoding for the behavioural counter library.
package b_cnt_pkg;

  localparam int unsigned DEF_WIDTH = 4;
  localparam int unsigned DEF_MOD   = 16;

  typedef logic [1:0] op_t;

  localparam op_t OP_HOLD = 2'd0;
  localparam op_t OP_CNT  = 2'd1;
  localparam op_t OP_LD   = 2'd2;
  localparam op_t OP_CLR  = 2'd3;

  // Resolve the per-edge action: clr over ld over en over hold.
  function automatic op_t op_sel(input logic clr, input logic ld, input logic en);
    if (clr) begin
      return OP_CLR;
    end else if (ld) begin
      return OP_LD;
    end else if (en) begin
      return OP_CNT;
    end else begin
      return OP_HOLD;
    end
  endfunction

endpackage

// File: rtl/b_cnt_tc.sv
// Combinational terminal-count / cascade-carry decoder; TC_VAL is MOD-1 for up counters, 0 for down.
module b_cnt_tc #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned TC_VAL = 15
) (
  input  logic [WIDTH-1:0] c,
  input  logic             en,
  input  logic             clr,
  input  logic             ld,
  output logic             tc_c,
  output logic             co_c
);

  localparam logic [WIDTH-1:0] TC_CMP = WIDTH'(TC_VAL);

  always_comb begin
    tc_c = (c == TC_CMP);
    co_c = tc_c & en & ~clr & ~ld;
  end

endmodule

// File: rtl/b_syn_up.sv
// Synchronous modulo-MOD up counter with enable, load, clear, terminal count and cascade carry.
// Optional sticky wrap flag ovf when B_SYN_UP_OVF_EN is defined.
module b_syn_up
  import b_cnt_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned MOD   = DEF_MOD
) (
  input  logic             clk,
  input  logic             re,
  input  logic             en,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] c,
  output logic             tc,
  output logic             co
`ifdef B_SYN_UP_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [WIDTH-1:0] MAXC  = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_W = (WIDTH + 1)'(MOD);

  op_t             op;
  logic [WIDTH-1:0] c_nxt;

  b_cnt_tc #(
    .WIDTH  (WIDTH),
    .TC_VAL (MOD - 1)
  ) u_tc (
    .c    (c),
    .en   (en),
    .clr  (clr),
    .ld   (ld),
    .tc_c (tc),
    .co_c (co)
  );

  // Next count; wrap comes from the MOD-1 compare, not natural overflow.
  always_comb begin
    op    = op_sel(clr, ld, en);
    c_nxt = c;
    case (op)
      OP_CLR:  c_nxt = '0;
      OP_LD:   c_nxt = ({1'b0, d} < MOD_W) ? d : '0;
      OP_CNT:  c_nxt = (c == MAXC) ? '0 : c + WIDTH'(1);
      default: c_nxt = c;
    endcase
  end

  always_ff @(posedge clk or negedge re) begin
    if (!re) begin
      c <= '0;
    end else begin
      c <= c_nxt;
    end
  end

`ifdef B_SYN_UP_OVF_EN
  // co is high exactly on a wrapping edge, so it doubles as the set term.
  always_ff @(posedge clk or negedge re) begin
    if (!re) begin
      ovf <= 1'b0;
    end else if (op == OP_CLR) begin
      ovf <= 1'b0;
    end else if (co) begin
      ovf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_b_syn_up.sv
// Randomized self-checking bench for b_syn_up: MOD=16, MOD=10 and a two-stage cascade.
// Exercises the sticky ovf flag when B_SYN_UP_OVF_EN is defined.
module tb_b_syn_up;

  logic       clk = 1'b0;
  logic       re, en, clr, ld, cas_en;
  logic [3:0] d;
  logic [3:0] c16, c10, cl, ch;
  logic       tc16, co16, tc10, co10, tcl, col, tch, coh;
`ifdef B_SYN_UP_OVF_EN
  logic       ov16, ov10, ovl, ovh;
`endif

  int n_chk = 0;
  int n_err = 0;
  int m16 = 0, m10 = 0, m8 = 0;
  int o16 = 0, o10 = 0, o8 = 0;

  always #5 clk = ~clk;

  b_syn_up #(.WIDTH(4), .MOD(16)) u_d16 (
    .clk(clk), .re(re), .en(en), .clr(clr), .ld(ld), .d(d),
    .c(c16), .tc(tc16), .co(co16)
`ifdef B_SYN_UP_OVF_EN
    , .ovf(ov16)
`endif
  );

  b_syn_up #(.WIDTH(4), .MOD(10)) u_d10 (
    .clk(clk), .re(re), .en(en), .clr(clr), .ld(ld), .d(d),
    .c(c10), .tc(tc10), .co(co10)
`ifdef B_SYN_UP_OVF_EN
    , .ovf(ov10)
`endif
  );

  b_syn_up #(.WIDTH(4), .MOD(16)) u_lo (
    .clk(clk), .re(re), .en(cas_en), .clr(1'b0), .ld(1'b0), .d(4'd0),
    .c(cl), .tc(tcl), .co(col)
`ifdef B_SYN_UP_OVF_EN
    , .ovf(ovl)
`endif
  );

  b_syn_up #(.WIDTH(4), .MOD(16)) u_hi (
    .clk(clk), .re(re), .en(col), .clr(1'b0), .ld(1'b0), .d(4'd0),
    .c(ch), .tc(tch), .co(coh)
`ifdef B_SYN_UP_OVF_EN
    , .ovf(ovh)
`endif
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_next(input int m, input int mod, input bit c_, input bit l_,
                                  input bit e_, input int dv);
    if (c_) return 0;
    if (l_) return (dv < mod) ? dv : 0;
    if (e_) return (m + 1) % mod;
    return m;
  endfunction

  function automatic int ref_ovf(input int o, input int m, input int mod, input bit c_,
                                 input bit l_, input bit e_);
    if (c_) return 0;
    if (!l_ && e_ && m == mod - 1) return 1;
    return o;
  endfunction

  task automatic check_comb();
    bit lo_tc, hi_tc;
    chk("tc16", int'(tc16), int'(m16 == 15));
    chk("co16", int'(co16), int'(m16 == 15 && en && !clr && !ld));
    chk("tc10", int'(tc10), int'(m10 == 9));
    chk("co10", int'(co10), int'(m10 == 9 && en && !clr && !ld));
    lo_tc = (m8 % 16 == 15);
    hi_tc = (m8 / 16 == 15);
    chk("cas_tc_lo", int'(tcl), int'(lo_tc));
    chk("cas_co_lo", int'(col), int'(lo_tc && cas_en));
    chk("cas_tc_hi", int'(tch), int'(hi_tc));
    chk("cas_co_hi", int'(coh), int'(hi_tc && lo_tc && cas_en));
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_c16"}, int'(c16), m16);
    chk({tag, "_c10"}, int'(c10), m10);
    chk({tag, "_c10_range"}, int'(c10 < 4'd10), 1);
    chk({tag, "_cas"}, int'({ch, cl}), m8);
`ifdef B_SYN_UP_OVF_EN
    chk({tag, "_ovf16"}, int'(ov16), o16);
    chk({tag, "_ovf10"}, int'(ov10), o10);
    chk({tag, "_ovf_lo"}, int'(ovl), o8);
`endif
  endtask

  task automatic drive(input bit e_, input bit c_, input bit l_, input logic [3:0] dv);
    en  = e_;
    clr = c_;
    ld  = l_;
    d   = dv;
    #1;
    check_comb();
  endtask

  task automatic tick(input string tag);
    int n16, n10, n8;
    n16 = ref_next(m16, 16, clr, ld, en, int'(d));
    n10 = ref_next(m10, 10, clr, ld, en, int'(d));
    n8  = cas_en ? (m8 + 1) % 256 : m8;
    o16 = ref_ovf(o16, m16, 16, clr, ld, en);
    o10 = ref_ovf(o10, m10, 10, clr, ld, en);
    o8  = ref_ovf(o8, m8 % 16, 16, 1'b0, 1'b0, cas_en);
    @(posedge clk);
    #1;
    m16 = n16;
    m10 = n10;
    m8  = n8;
    check_state(tag);
  endtask

  task automatic reset_model();
    m16 = 0; m10 = 0; m8 = 0;
    o16 = 0; o10 = 0; o8 = 0;
  endtask

  initial begin
    re = 1'b0; en = 1'b0; clr = 1'b0; ld = 1'b0; d = 4'd0; cas_en = 1'b0;
    #12;
    check_state("in_reset");
    check_comb();
    @(negedge clk);
    re = 1'b1;

    // Free run long enough for MOD=16, MOD=10 and the full 8-bit cascade to wrap.
    cas_en = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 300; i++) begin
      tick("run");
      check_comb();
    end

    // Load and priority corner cases.
    drive(1'b0, 1'b0, 1'b1, 4'd7);  tick("ld7");
    drive(1'b1, 1'b1, 1'b1, 4'd5);  tick("clr_ld");
    drive(1'b0, 1'b0, 1'b1, 4'd12); tick("ld12");
    drive(1'b0, 1'b0, 1'b1, 4'd9);  tick("ld9");
    drive(1'b1, 1'b0, 1'b1, 4'd3);  tick("ld_over_wrap");
    drive(1'b1, 1'b0, 1'b0, 4'd0);  tick("cnt_after_ld");

    // Asynchronous reset between edges, with a count pending.
    drive(1'b0, 1'b0, 1'b1, 4'd6);  tick("ld6");
    drive(1'b1, 1'b0, 1'b1, 4'd2);
    #1;
    re = 1'b0;
    #1;
    reset_model();
    check_state("async_rst");
    @(posedge clk);
    #1;
    check_state("rst_hold");
    @(negedge clk);
    re = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 12; i++) begin
      tick("resume");
      check_comb();
    end

    // Randomized mix of all controls.
    for (int i = 0; i < 3000; i++) begin
      cas_en = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 7) == 0, 4'($urandom));
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
